// File: rtl/glb_tile_cfg_router_if.sv
// ---------------------------------------------------------------------------
// glb_tile_cfg_router_if
//  Bundles every config packet path and status line of the tile config
//  router. A packet is {rd_en, wr_en, addr, data}.
//  slave  : router view (i_* inputs, o_* outputs)
//  master : driver view (opposite directions)
//  Signals:
//   i_cfg_pc_dma_mode      1: PC source is c2sw, 0: pc_wsti
//   i_cfg_col_mask         per-column enable for write/PC packets
//   i_c2sw_*               DMA-generated config packet
//   i_jtag_wsti_*          JTAG packet from west neighbour
//   o_jtag_esto_*          JTAG packet to east neighbour
//   i_pc_wsti_*            PC packet from west neighbour
//   o_pc_esto_*            PC packet to east neighbour
//   o_g2f_*                per-column CGRA config ports (packed by column)
//   i/o_jtag_rd_bypass_*   JTAG read bypass in/out
//   o_pc_stall, o_pc_ovf   PC FIFO nearly-full / sticky drop flag
// ---------------------------------------------------------------------------
interface glb_tile_cfg_router_if #(
    parameter int unsigned NUM_COLS = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
);
    logic                               i_cfg_pc_dma_mode;
    logic [NUM_COLS-1:0]                i_cfg_col_mask;

    logic                               i_c2sw_rd_en;
    logic                               i_c2sw_wr_en;
    logic [ADDR_W-1:0]                  i_c2sw_addr;
    logic [DATA_W-1:0]                  i_c2sw_data;

    logic                               i_jtag_wsti_rd_en;
    logic                               i_jtag_wsti_wr_en;
    logic [ADDR_W-1:0]                  i_jtag_wsti_addr;
    logic [DATA_W-1:0]                  i_jtag_wsti_data;

    logic                               o_jtag_esto_rd_en;
    logic                               o_jtag_esto_wr_en;
    logic [ADDR_W-1:0]                  o_jtag_esto_addr;
    logic [DATA_W-1:0]                  o_jtag_esto_data;

    logic                               i_pc_wsti_rd_en;
    logic                               i_pc_wsti_wr_en;
    logic [ADDR_W-1:0]                  i_pc_wsti_addr;
    logic [DATA_W-1:0]                  i_pc_wsti_data;

    logic                               o_pc_esto_rd_en;
    logic                               o_pc_esto_wr_en;
    logic [ADDR_W-1:0]                  o_pc_esto_addr;
    logic [DATA_W-1:0]                  o_pc_esto_data;

    logic [NUM_COLS-1:0]                o_g2f_rd_en;
    logic [NUM_COLS-1:0]                o_g2f_wr_en;
    logic [NUM_COLS-1:0][ADDR_W-1:0]    o_g2f_addr;
    logic [NUM_COLS-1:0][DATA_W-1:0]    o_g2f_data;

    logic                               i_jtag_rd_bypass_wsti_rd_en;
    logic [ADDR_W-1:0]                  i_jtag_rd_bypass_wsti_addr;
    logic                               o_jtag_rd_bypass_esto_rd_en;
    logic [ADDR_W-1:0]                  o_jtag_rd_bypass_esto_addr;

    logic                               o_pc_stall;
    logic                               o_pc_ovf;

    modport slave (
        input  i_cfg_pc_dma_mode, i_cfg_col_mask,
        input  i_c2sw_rd_en, i_c2sw_wr_en, i_c2sw_addr, i_c2sw_data,
        input  i_jtag_wsti_rd_en, i_jtag_wsti_wr_en, i_jtag_wsti_addr, i_jtag_wsti_data,
        output o_jtag_esto_rd_en, o_jtag_esto_wr_en, o_jtag_esto_addr, o_jtag_esto_data,
        input  i_pc_wsti_rd_en, i_pc_wsti_wr_en, i_pc_wsti_addr, i_pc_wsti_data,
        output o_pc_esto_rd_en, o_pc_esto_wr_en, o_pc_esto_addr, o_pc_esto_data,
        output o_g2f_rd_en, o_g2f_wr_en, o_g2f_addr, o_g2f_data,
        input  i_jtag_rd_bypass_wsti_rd_en, i_jtag_rd_bypass_wsti_addr,
        output o_jtag_rd_bypass_esto_rd_en, o_jtag_rd_bypass_esto_addr,
        output o_pc_stall, o_pc_ovf
    );

    modport master (
        output i_cfg_pc_dma_mode, i_cfg_col_mask,
        output i_c2sw_rd_en, i_c2sw_wr_en, i_c2sw_addr, i_c2sw_data,
        output i_jtag_wsti_rd_en, i_jtag_wsti_wr_en, i_jtag_wsti_addr, i_jtag_wsti_data,
        input  o_jtag_esto_rd_en, o_jtag_esto_wr_en, o_jtag_esto_addr, o_jtag_esto_data,
        output i_pc_wsti_rd_en, i_pc_wsti_wr_en, i_pc_wsti_addr, i_pc_wsti_data,
        input  o_pc_esto_rd_en, o_pc_esto_wr_en, o_pc_esto_addr, o_pc_esto_data,
        input  o_g2f_rd_en, o_g2f_wr_en, o_g2f_addr, o_g2f_data,
        output i_jtag_rd_bypass_wsti_rd_en, i_jtag_rd_bypass_wsti_addr,
        input  o_jtag_rd_bypass_esto_rd_en, o_jtag_rd_bypass_esto_addr,
        input  o_pc_stall, o_pc_ovf
    );
endinterface

// File: rtl/glb_tile_cfg_router.sv
// ---------------------------------------------------------------------------
// glb_tile_cfg_router
//  Tile config switch: forwards JTAG and PC packets east with one register
//  stage, and feeds NUM_COLS CGRA config ports through a strict-priority
//  arbiter (rd bypass > JTAG > PC FIFO head > PC direct). PC packets that
//  lose arbitration queue in a small FIFO; the per-column mask gates every
//  packet except read bypass; the chosen packet then passes PIPE_DEPTH
//  register stages before reaching the g2f ports.
//  Ports:
//   clk      clock
//   reset    asynchronous, active-high
//   io_cfg   glb_tile_cfg_router_if.slave (all packet/status signals)
//   o_perf_wr_cnt, o_perf_stall_cnt  (only with CFG_ROUTER_PERF_CNT_EN)
//  Optional feature macro: CFG_ROUTER_PERF_CNT_EN adds saturating counters
//  of stage-0 g2f writes and of pc_stall cycles.
// ---------------------------------------------------------------------------
module glb_tile_cfg_router #(
    parameter int unsigned NUM_COLS      = 4,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned PIPE_DEPTH    = 1,
    parameter int unsigned PC_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    glb_tile_cfg_router_if.slave  io_cfg
`ifdef CFG_ROUTER_PERF_CNT_EN
    ,
    output logic [31:0]           o_perf_wr_cnt,
    output logic [31:0]           o_perf_stall_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(PC_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(PC_FIFO_DEPTH + 1);

    // East chain registers
    logic              r_jtag_rd, r_jtag_wr;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic [DATA_W-1:0] r_jtag_data;
    logic              r_pc_rd, r_pc_wr;
    logic [ADDR_W-1:0] r_pc_addr;
    logic [DATA_W-1:0] r_pc_data;

    // PC collision FIFO
    logic              r_fifo_rd   [PC_FIFO_DEPTH];
    logic              r_fifo_wr   [PC_FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [PC_FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [PC_FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_pc_stall, r_pc_ovf;

    // Arbiter result
    logic              w_sel_rd, w_sel_wr, w_sel_byp;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_pop, w_pc_grant, w_push, w_push_ok, w_full;
    logic              w_jtag_v, w_pc_v, w_fifo_ne;

    // Output pipeline
    logic [NUM_COLS-1:0]                                w_col_en;
    logic [PIPE_DEPTH-1:0][NUM_COLS-1:0]                r_p_rd, r_p_wr, w_p_rd_nxt, w_p_wr_nxt;
    logic [PIPE_DEPTH-1:0][NUM_COLS-1:0][ADDR_W-1:0]    r_p_addr, w_p_addr_nxt;
    logic [PIPE_DEPTH-1:0][NUM_COLS-1:0][DATA_W-1:0]    r_p_data, w_p_data_nxt;

    // Read bypass is a pure wire path
    assign io_cfg.o_jtag_rd_bypass_esto_rd_en = io_cfg.i_jtag_rd_bypass_wsti_rd_en;
    assign io_cfg.o_jtag_rd_bypass_esto_addr  = io_cfg.i_jtag_rd_bypass_wsti_addr;

    // East forwarding, independent of arbitration and stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jtag_rd   <= 1'b0;
            r_jtag_wr   <= 1'b0;
            r_jtag_addr <= '0;
            r_jtag_data <= '0;
            r_pc_rd     <= 1'b0;
            r_pc_wr     <= 1'b0;
            r_pc_addr   <= '0;
            r_pc_data   <= '0;
        end else begin
            r_jtag_rd   <= io_cfg.i_jtag_wsti_rd_en;
            r_jtag_wr   <= io_cfg.i_jtag_wsti_wr_en;
            r_jtag_addr <= io_cfg.i_jtag_wsti_addr;
            r_jtag_data <= io_cfg.i_jtag_wsti_data;
            if (io_cfg.i_cfg_pc_dma_mode) begin
                r_pc_rd   <= io_cfg.i_c2sw_rd_en;
                r_pc_wr   <= io_cfg.i_c2sw_wr_en;
                r_pc_addr <= io_cfg.i_c2sw_addr;
                r_pc_data <= io_cfg.i_c2sw_data;
            end else begin
                r_pc_rd   <= io_cfg.i_pc_wsti_rd_en;
                r_pc_wr   <= io_cfg.i_pc_wsti_wr_en;
                r_pc_addr <= io_cfg.i_pc_wsti_addr;
                r_pc_data <= io_cfg.i_pc_wsti_data;
            end
        end
    end

    assign io_cfg.o_jtag_esto_rd_en = r_jtag_rd;
    assign io_cfg.o_jtag_esto_wr_en = r_jtag_wr;
    assign io_cfg.o_jtag_esto_addr  = r_jtag_addr;
    assign io_cfg.o_jtag_esto_data  = r_jtag_data;
    assign io_cfg.o_pc_esto_rd_en   = r_pc_rd;
    assign io_cfg.o_pc_esto_wr_en   = r_pc_wr;
    assign io_cfg.o_pc_esto_addr    = r_pc_addr;
    assign io_cfg.o_pc_esto_data    = r_pc_data;

    assign w_jtag_v  = r_jtag_rd | r_jtag_wr;
    assign w_pc_v    = r_pc_rd | r_pc_wr;
    assign w_fifo_ne = (r_count != '0);
    assign w_full    = (r_count == CNT_W'(PC_FIFO_DEPTH));

    // Strict-priority arbiter; the direct PC path is only taken with an
    // empty FIFO so PC packets never overtake queued ones
    always_comb begin
        w_sel_rd   = 1'b0;
        w_sel_wr   = 1'b0;
        w_sel_byp  = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_pop      = 1'b0;
        w_pc_grant = 1'b0;
        if (io_cfg.i_jtag_rd_bypass_wsti_rd_en) begin
            w_sel_rd   = 1'b1;
            w_sel_byp  = 1'b1;
            w_sel_addr = io_cfg.i_jtag_rd_bypass_wsti_addr;
        end else if (w_jtag_v) begin
            w_sel_rd   = r_jtag_rd;
            w_sel_wr   = r_jtag_wr;
            w_sel_addr = r_jtag_addr;
            w_sel_data = r_jtag_data;
        end else if (w_fifo_ne) begin
            w_sel_rd   = r_fifo_rd[r_rptr];
            w_sel_wr   = r_fifo_wr[r_rptr];
            w_sel_addr = r_fifo_addr[r_rptr];
            w_sel_data = r_fifo_data[r_rptr];
            w_pop      = 1'b1;
        end else if (w_pc_v) begin
            w_sel_rd   = r_pc_rd;
            w_sel_wr   = r_pc_wr;
            w_sel_addr = r_pc_addr;
            w_sel_data = r_pc_data;
            w_pc_grant = 1'b1;
        end
    end

    // Push+pop at full is legal: the head slot is read before it is rewritten
    assign w_push    = w_pc_v & ~w_pc_grant;
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_rd[r_wptr]   <= r_pc_rd;
            r_fifo_wr[r_wptr]   <= r_pc_wr;
            r_fifo_addr[r_wptr] <= r_pc_addr;
            r_fifo_data[r_wptr] <= r_pc_data;
        end
    end

    // FIFO control and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pc_stall <= 1'b0;
            r_pc_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_pc_stall <= (w_count_nxt >= CNT_W'(PC_FIFO_DEPTH - 1));
            if (w_push && w_full && !w_pop) begin
                r_pc_ovf <= 1'b1;
            end
        end
    end

    assign io_cfg.o_pc_stall = r_pc_stall;
    assign io_cfg.o_pc_ovf   = r_pc_ovf;

    // Read bypass reaches every column regardless of the mask
    assign w_col_en = {NUM_COLS{w_sel_byp}} | io_cfg.i_cfg_col_mask;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        assign w_p_rd_nxt[0][c]   = w_col_en[c] & w_sel_rd;
        assign w_p_wr_nxt[0][c]   = w_col_en[c] & w_sel_wr;
        assign w_p_addr_nxt[0][c] = w_col_en[c] ? w_sel_addr : '0;
        assign w_p_data_nxt[0][c] = w_col_en[c] ? w_sel_data : '0;
    end

    for (genvar s = 1; s < PIPE_DEPTH; s++) begin : g_stage
        assign w_p_rd_nxt[s]   = r_p_rd[s-1];
        assign w_p_wr_nxt[s]   = r_p_wr[s-1];
        assign w_p_addr_nxt[s] = r_p_addr[s-1];
        assign w_p_data_nxt[s] = r_p_data[s-1];
    end

    // Output pipeline, last stage drives the g2f ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_rd   <= '0;
            r_p_wr   <= '0;
            r_p_addr <= '0;
            r_p_data <= '0;
        end else begin
            r_p_rd   <= w_p_rd_nxt;
            r_p_wr   <= w_p_wr_nxt;
            r_p_addr <= w_p_addr_nxt;
            r_p_data <= w_p_data_nxt;
        end
    end

    assign io_cfg.o_g2f_rd_en = r_p_rd[PIPE_DEPTH-1];
    assign io_cfg.o_g2f_wr_en = r_p_wr[PIPE_DEPTH-1];
    assign io_cfg.o_g2f_addr  = r_p_addr[PIPE_DEPTH-1];
    assign io_cfg.o_g2f_data  = r_p_data[PIPE_DEPTH-1];

`ifdef CFG_ROUTER_PERF_CNT_EN
    logic [31:0] r_perf_wr_cnt, r_perf_stall_cnt;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_wr_cnt    <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if ((|r_p_wr[0]) && (r_perf_wr_cnt != '1)) begin
                r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
            end
            if (r_pc_stall && (r_perf_stall_cnt != '1)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign o_perf_wr_cnt    = r_perf_wr_cnt;
    assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_glb_tile_cfg_router.sv
// ---------------------------------------------------------------------------
// tb_glb_tile_cfg_router
//  Table of single-shot vectors plus hand-written burst and reset sequences.
//  Expected g2f packets are queued with their due cycle when stimulus is
//  driven and compared when that cycle is reached; every other cycle the
//  g2f ports must be all-zero.
// ---------------------------------------------------------------------------
module tb_glb_tile_cfg_router;
    localparam int unsigned NC = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2*NC + NC*AW + NC*DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    glb_tile_cfg_router_if #(.NUM_COLS(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef CFG_ROUTER_PERF_CNT_EN
    logic [31:0] perf_wr_cnt, perf_stall_cnt;
`endif

    glb_tile_cfg_router #(
        .NUM_COLS(NC), .ADDR_W(AW), .DATA_W(DW), .PIPE_DEPTH(1), .PC_FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_cfg (bus)
`ifdef CFG_ROUTER_PERF_CNT_EN
        ,
        .o_perf_wr_cnt    (perf_wr_cnt),
        .o_perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        int           cyc;
        logic [CW-1:0] val;
        string        nm;
    } exp_t;

    typedef struct {
        string       nm;
        logic        mode;
        logic [3:0]  mask;
        logic        j_rd, j_wr;
        logic [31:0] j_addr, j_data;
        logic        p_rd, p_wr;
        logic [31:0] p_addr, p_data;
        logic        b_rd;
        logic [31:0] b_addr;
        int          j_lat, p_lat, b_lat;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] g2f_now();
        return {bus.o_g2f_rd_en, bus.o_g2f_wr_en, bus.o_g2f_addr, bus.o_g2f_data};
    endfunction

    function automatic logic [CW-1:0] mk_exp(input logic rd, input logic wr,
                                             input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] en);
        logic [NC-1:0]         r, w;
        logic [NC-1:0][AW-1:0] a;
        logic [NC-1:0][DW-1:0] d;
        for (int i = 0; i < NC; i++) begin
            r[i] = rd & en[i];
            w[i] = wr & en[i];
            a[i] = en[i] ? addr : 32'h0;
            d[i] = en[i] ? data : 32'h0;
        end
        return {r, w, a, d};
    endfunction

    task automatic push_exp(input string nm, input int at, input logic [CW-1:0] v);
        exp_t e;
        int   idx;
        e.cyc = at;
        e.val = v;
        e.nm  = nm;
        idx   = sb.size();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc > at) idx = i;
        end
        sb.insert(idx, e);
    endtask

    // Advance one clock, then compare g2f against the scoreboard
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk(e.nm, g2f_now(), e.val);
        end else begin
            chk("g2f_idle", g2f_now(), '0);
        end
    endtask

    task automatic clr_in();
        bus.i_c2sw_rd_en = 0; bus.i_c2sw_wr_en = 0; bus.i_c2sw_addr = 0; bus.i_c2sw_data = 0;
        bus.i_jtag_wsti_rd_en = 0; bus.i_jtag_wsti_wr_en = 0;
        bus.i_jtag_wsti_addr = 0; bus.i_jtag_wsti_data = 0;
        bus.i_pc_wsti_rd_en = 0; bus.i_pc_wsti_wr_en = 0;
        bus.i_pc_wsti_addr = 0; bus.i_pc_wsti_data = 0;
        bus.i_jtag_rd_bypass_wsti_rd_en = 0; bus.i_jtag_rd_bypass_wsti_addr = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_g2f"}, g2f_now(), '0);
        chk({nm, "_jtag_esto"}, CW'({bus.o_jtag_esto_rd_en, bus.o_jtag_esto_wr_en,
                                     bus.o_jtag_esto_addr, bus.o_jtag_esto_data}), '0);
        chk({nm, "_pc_esto"}, CW'({bus.o_pc_esto_rd_en, bus.o_pc_esto_wr_en,
                                   bus.o_pc_esto_addr, bus.o_pc_esto_data}), '0);
        chk({nm, "_stall"}, CW'(bus.o_pc_stall), '0);
        chk({nm, "_ovf"}, CW'(bus.o_pc_ovf), '0);
    endtask

    function automatic vec_t mkv(input string nm, input logic mode, input logic [3:0] mask,
                                 input logic j_rd, input logic j_wr,
                                 input logic [31:0] j_addr, input logic [31:0] j_data,
                                 input logic p_rd, input logic p_wr,
                                 input logic [31:0] p_addr, input logic [31:0] p_data,
                                 input logic b_rd, input logic [31:0] b_addr,
                                 input int j_lat, input int p_lat, input int b_lat);
        vec_t v;
        v.nm = nm; v.mode = mode; v.mask = mask;
        v.j_rd = j_rd; v.j_wr = j_wr; v.j_addr = j_addr; v.j_data = j_data;
        v.p_rd = p_rd; v.p_wr = p_wr; v.p_addr = p_addr; v.p_data = p_data;
        v.b_rd = b_rd; v.b_addr = b_addr;
        v.j_lat = j_lat; v.p_lat = p_lat; v.b_lat = b_lat;
        return v;
    endfunction

    initial begin
        int n;
        // Latencies: JTAG 2 (east reg + 1 pipe), PC 2 direct / 3 behind JTAG,
        // rd bypass 1 (wire into the pipe)
        tbl[0] = mkv("jtag_wr",     0, 4'hF, 0, 1, 32'h10, 32'hAB, 0, 0, 0, 0,            0, 0,     2, 0, 0);
        tbl[1] = mkv("jtag_pc_col", 0, 4'hF, 0, 1, 32'h11, 32'h01, 0, 1, 32'h20, 32'h02,  0, 0,     2, 3, 0);
        tbl[2] = mkv("pc_mask",     0, 4'h5, 0, 0, 0, 0,           0, 1, 32'h30, 32'h55,  0, 0,     0, 2, 0);
        tbl[3] = mkv("byp_mask",    0, 4'h5, 0, 0, 0, 0,           0, 0, 0, 0,            1, 32'h44, 0, 0, 1);
        tbl[4] = mkv("c2sw_mode",   1, 4'hF, 0, 0, 0, 0,           0, 1, 32'h60, 32'h66,  0, 0,     0, 2, 0);
        tbl[5] = mkv("jtag_rd_msk", 0, 4'h3, 1, 0, 32'h70, 0,      0, 0, 0, 0,            0, 0,     2, 0, 0);
        tbl[6] = mkv("byp_pc",      0, 4'hF, 0, 0, 0, 0,           0, 1, 32'h80, 32'h88,  1, 32'h48, 0, 2, 1);
        tbl[7] = mkv("byp_jtag_pc", 0, 4'hA, 0, 1, 32'h90, 32'h99, 1, 0, 32'hA0, 32'h0,   1, 32'h4C, 2, 3, 1);

        // Reset state
        reset = 1'b1;
        clr_in();
        bus.i_cfg_pc_dma_mode = 0;
        bus.i_cfg_col_mask    = 4'hF;
        #2;
        chk_all_zero("reset_init");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) step();

        // Table-driven single-shot vectors
        for (int v = 0; v < 8; v++) begin
            bus.i_cfg_col_mask    = tbl[v].mask;
            bus.i_cfg_pc_dma_mode = tbl[v].mode;
            bus.i_jtag_wsti_rd_en = tbl[v].j_rd;
            bus.i_jtag_wsti_wr_en = tbl[v].j_wr;
            bus.i_jtag_wsti_addr  = tbl[v].j_addr;
            bus.i_jtag_wsti_data  = tbl[v].j_data;
            // The unselected PC source carries a junk packet that must be ignored
            if (tbl[v].mode) begin
                bus.i_c2sw_rd_en = tbl[v].p_rd; bus.i_c2sw_wr_en = tbl[v].p_wr;
                bus.i_c2sw_addr  = tbl[v].p_addr; bus.i_c2sw_data = tbl[v].p_data;
                bus.i_pc_wsti_wr_en = 1; bus.i_pc_wsti_addr = 32'hDEAD; bus.i_pc_wsti_data = 32'hBAD;
            end else begin
                bus.i_pc_wsti_rd_en = tbl[v].p_rd; bus.i_pc_wsti_wr_en = tbl[v].p_wr;
                bus.i_pc_wsti_addr  = tbl[v].p_addr; bus.i_pc_wsti_data = tbl[v].p_data;
                bus.i_c2sw_wr_en = 1; bus.i_c2sw_addr = 32'hDEAD; bus.i_c2sw_data = 32'hBAD;
            end
            bus.i_jtag_rd_bypass_wsti_rd_en = tbl[v].b_rd;
            bus.i_jtag_rd_bypass_wsti_addr  = tbl[v].b_addr;
            n = cyc;
            if (tbl[v].j_rd | tbl[v].j_wr)
                push_exp({tbl[v].nm, "_jtag"}, n + tbl[v].j_lat,
                         mk_exp(tbl[v].j_rd, tbl[v].j_wr, tbl[v].j_addr, tbl[v].j_data, tbl[v].mask));
            if (tbl[v].p_rd | tbl[v].p_wr)
                push_exp({tbl[v].nm, "_pc"}, n + tbl[v].p_lat,
                         mk_exp(tbl[v].p_rd, tbl[v].p_wr, tbl[v].p_addr, tbl[v].p_data, tbl[v].mask));
            if (tbl[v].b_rd)
                push_exp({tbl[v].nm, "_byp"}, n + tbl[v].b_lat,
                         mk_exp(1'b1, 1'b0, tbl[v].b_addr, 32'h0, 4'hF));
            #1;
            chk({tbl[v].nm, "_byp_esto"},
                CW'({bus.o_jtag_rd_bypass_esto_rd_en, bus.o_jtag_rd_bypass_esto_addr}),
                CW'({tbl[v].b_rd, tbl[v].b_addr}));
            step();
            chk({tbl[v].nm, "_jtag_esto"},
                CW'({bus.o_jtag_esto_rd_en, bus.o_jtag_esto_wr_en, bus.o_jtag_esto_addr, bus.o_jtag_esto_data}),
                CW'({tbl[v].j_rd, tbl[v].j_wr, tbl[v].j_addr, tbl[v].j_data}));
            chk({tbl[v].nm, "_pc_esto"},
                CW'({bus.o_pc_esto_rd_en, bus.o_pc_esto_wr_en, bus.o_pc_esto_addr, bus.o_pc_esto_data}),
                CW'({tbl[v].p_rd, tbl[v].p_wr, tbl[v].p_addr, tbl[v].p_data}));
            clr_in();
            for (int i = 0; i < 5; i++) begin
                chk({tbl[v].nm, "_stall"}, CW'(bus.o_pc_stall), '0);
                step();
            end
        end

        // Burst: 5 JTAG + 5 PC writes back-to-back. PC0..3 queue and drain
        // after the JTAG run; PC4 meets a full FIFO with no pop and is dropped.
        bus.i_cfg_pc_dma_mode = 0;
        bus.i_cfg_col_mask    = 4'hF;
        n = cyc;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("burst_stall_k%0d", k), CW'(bus.o_pc_stall), CW'((k >= 4 && k <= 7) ? 1 : 0));
            chk($sformatf("burst_ovf_k%0d", k), CW'(bus.o_pc_ovf), CW'((k >= 6) ? 1 : 0));
            if (k < 5) begin
                bus.i_jtag_wsti_wr_en = 1;
                bus.i_jtag_wsti_addr  = 32'h100 + 32'(k);
                bus.i_jtag_wsti_data  = 32'h1000 + 32'(k);
                bus.i_pc_wsti_wr_en   = 1;
                bus.i_pc_wsti_addr    = 32'h200 + 32'(k);
                bus.i_pc_wsti_data    = 32'h2000 + 32'(k);
                push_exp($sformatf("burst_jtag%0d", k), n + k + 2,
                         mk_exp(1'b0, 1'b1, 32'h100 + 32'(k), 32'h1000 + 32'(k), 4'hF));
                if (k < 4)
                    push_exp($sformatf("burst_pc%0d", k), n + k + 7,
                             mk_exp(1'b0, 1'b1, 32'h200 + 32'(k), 32'h2000 + 32'(k), 4'hF));
            end else begin
                clr_in();
            end
            step();
        end
        chk("ovf_sticky", CW'(bus.o_pc_ovf), CW'(1));
`ifdef CFG_ROUTER_PERF_CNT_EN
        chk("perf_stall_cnt", CW'(perf_stall_cnt), CW'(4));
`endif

        // Reset mid-stream: in-flight packets are lost, everything clears
        bus.i_jtag_wsti_wr_en = 1; bus.i_jtag_wsti_addr = 32'h300; bus.i_jtag_wsti_data = 32'h3;
        bus.i_pc_wsti_wr_en   = 1; bus.i_pc_wsti_addr   = 32'h301; bus.i_pc_wsti_data   = 32'h4;
        step();
        #1;
        reset = 1'b1;
        clr_in();
        sb.delete();
        #1;
        chk_all_zero("reset_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_all_zero("post_reset");

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got nothing by cycle %0d, want %h at cycle %0d", e.nm, cyc, e.val, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
